// File: rtl/rv_pkg.sv
// Shared RV64 load/store definitions: opcodes, func3 width codes, lsu state encoding
// and the alignment/legality rule for a single access.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_RSP,
    LSU_DONE,
    LSU_ERR
  } lsu_state_t;

  // Unsigned widths exist only for loads; func3=111 is never legal.
  function automatic logic lsu_access_ok(input logic we, input logic [2:0] f3,
                                         input logic [2:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off[1:0] == 2'b00);
      F3_D:    ok = (off == 3'b000);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      F3_WU:   ok = ~we & (off[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane shift/strobe generation and load shift/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers both paths.
module lsu_align
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      st_size,
  input  logic [2:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [7:0]      st_wstrb,
  input  logic [2:0]      ld_func3,
  input  logic [2:0]      ld_off,
  input  logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] ld_result
);

  logic [7:0]      base_strb;
  logic [XLEN-1:0] ld_shift;

  always_comb begin
    case (st_size)
      2'd0:    base_strb = 8'h01;
      2'd1:    base_strb = 8'h03;
      2'd2:    base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
    st_wstrb = base_strb << st_off;
    st_wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    ld_shift = ld_data >> {ld_off, 3'b000};
    case (ld_func3)
      F3_B:    ld_result = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_result = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      F3_W:    ld_result = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
      F3_BU:   ld_result = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      F3_HU:   ld_result = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      F3_WU:   ld_result = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
      default: ld_result = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV64 load/store sequencer; LSU_TIMEOUT_EN adds a REQ/WAIT_RSP abort counter.
// Latency: store 3 cycles, load 4 cycles with zero-wait memory; rejected accesses 2 cycles.
// Backpressure: request held stable in REQ until mem_req_ready; WAIT_RSP waits for mem_rsp_valid.
module lsu_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN = 64
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_func3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            stall,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err_misalign,
  output logic            err_timeout
);

  lsu_state_t      state, state_n;
  logic            we_q;
  logic [2:0]      f3_q, off_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q, wdata_q, wb_data_q;
  logic [7:0]      wstrb_q;
  logic [XLEN-1:0] st_wdata, ld_result;
  logic [7:0]      st_wstrb;
  logic            req_ok, accept, tmo_fire;

  assign req_ok = lsu_access_ok(req_we, req_func3, req_addr[2:0]);
  assign accept = (state == LSU_IDLE) && req_valid && req_ok;

  // Store lanes come straight from the request; load lanes from the latched access.
  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size  (req_func3[1:0]),
    .st_off   (req_addr[2:0]),
    .st_data  (req_wdata),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_func3 (f3_q),
    .ld_off   (off_q),
    .ld_data  (mem_rdata),
    .ld_result(ld_result)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_q;

  assign tmo_fire = ((state == LSU_REQ) || (state == LSU_WAIT_RSP)) &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (accept)
        tmo_cnt <= '0;
      else if ((state == LSU_REQ) || (state == LSU_WAIT_RSP))
        tmo_cnt <= tmo_cnt + 1'b1;
      // ERR entered from IDLE is a rejected request; from REQ/WAIT_RSP it is an abort.
      if (state_n == LSU_ERR)
        tmo_q <= (state != LSU_IDLE);
    end
  end

  assign err_timeout  = (state == LSU_ERR) && tmo_q;
  assign err_misalign = (state == LSU_ERR) && !tmo_q;
`else
  assign tmo_fire     = 1'b0;
  assign err_timeout  = 1'b0;
  assign err_misalign = (state == LSU_ERR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    case (state)
      LSU_IDLE: begin
        stall = req_valid;
        if (req_valid) state_n = req_ok ? LSU_REQ : LSU_ERR;
      end
      LSU_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_n = we_q ? LSU_DONE : LSU_WAIT_RSP;
        else if (tmo_fire) state_n = LSU_ERR;
      end
      LSU_WAIT_RSP: begin
        stall = 1'b1;
        if (mem_rsp_valid) state_n = LSU_DONE;
        else if (tmo_fire) state_n = LSU_ERR;
      end
      LSU_DONE: begin
        wb_valid = !we_q;
        state_n  = LSU_IDLE;
      end
      LSU_ERR:  state_n = LSU_IDLE;
      default:  state_n = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wb_data_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_func3;
        off_q   <= req_addr[2:0];
        rd_q    <= req_rd;
        addr_q  <= {req_addr[XLEN-1:3], 3'b000};
        wdata_q <= st_wdata;
        wstrb_q <= req_we ? st_wstrb : 8'h00;
      end
      if ((state == LSU_WAIT_RSP) && mem_rsp_valid)
        wb_data_q <= ld_result;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Multi-cycle load/store sequencer for the RV64 core. It accepts one load or store per request from the decode/controller stage and stalls the PC and register file while the access is in flight. It drives a valid/ready data-memory port, aligns byte lanes, and returns a sign- or zero-extended write-back value for loads. Misaligned or illegal accesses are flagged and never reach memory.

Parameters:
XLEN, 64, data and address width in bits
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT_RSP before abort (only used with LSU_TIMEOUT_EN)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  current instruction is a load/store
req_we  in  1  1=store, 0=load
req_func3  in  3  RV func3 width/sign code
req_addr  in  XLEN  effective byte address (rs1+imm)
req_wdata  in  XLEN  store data (rs2)
req_rd  in  5  load destination register
stall  out  1  hold PC/regfile this cycle
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  XLEN  8-byte-aligned address (req_addr with [2:0]=0)
mem_wdata  out  XLEN  lane-shifted store data
mem_wstrb  out  8  byte strobes
mem_rsp_valid  in  1  load data valid
mem_rdata  in  XLEN  load data, 8-byte word
wb_valid  out  1  one-cycle load write-back strobe
wb_rd  out  5  write-back register
wb_data  out  XLEN  extended load result
err_misalign  out  1  one-cycle pulse on misaligned or illegal func3
err_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock is clk. Reset is asynchronous and active-low (rst_n).
- Reset, including mid-access: state goes to IDLE and every output goes to 0. mem_req_valid drops even if a handshake was pending.
- States: IDLE, REQ, WAIT_RSP, DONE, ERR.
- IDLE, req_valid=1:
  - Illegal func3 (store func3>=100, load func3=111) or misaligned address (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0) -> ERR.
  - Otherwise latch all req_* fields -> REQ.
- REQ:
  - mem_req_valid=1; mem_addr, mem_we, mem_wdata and mem_wstrb are registered and held stable until mem_req_ready.
  - On handshake: store -> DONE (posted write, no response); load -> WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid, shift mem_rdata right by addr[2:0]*8, then extend: LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD pass through. Register the result into wb_data -> DONE.
  - mem_rsp_valid in any other state is ignored.
- DONE:
  - stall=0; wb_valid=1 for loads only, with wb_rd latched; wb_valid=0 for stores.
  - Next state IDLE. req_valid is ignored this cycle (same instruction still presented).
- ERR:
  - stall=0; err_misalign=1 for one cycle; no memory access; no write-back -> IDLE.
- stall = (IDLE & req_valid) | REQ | WAIT_RSP. It is combinational.
  - Minimum latency: store 3 cycles (IDLE, REQ, DONE), load 4 cycles, with zero-wait memory.
- Store lanes:
  - SB/SH/SW/SD strobes 0x01/0x03/0x0F/0xFF, shifted left by addr[2:0].
  - mem_wdata = req_wdata shifted left by addr[2:0]*8.
- wb_data holds its last value outside DONE.

Optional Feature:
LSU_TIMEOUT_EN
- With the macro: an 8+-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT_RSP. When it reaches TIMEOUT_CYCLES, the block goes to ERR with err_timeout=1 (err_misalign=0), deasserts mem_req_valid, and suppresses write-back. A later mem_rsp_valid is ignored.
- Without the macro: the block waits indefinitely, the counter is absent and err_timeout is tied to 0.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OPC_LOAD=0000011 and OPC_STORE=0100011;
  - func3 constants F3_B/H/W/D/BU/HU/WU;
  - lsu state enum.
- One combinational sub-module, lsu_align, covers store lane shift/strobe generation and load shift/extend. It is instantiated twice or has separate store/load paths.

Test Plan:
- LB addr=0x1003, mem_rdata=0x00000000_80000000, zero-wait -> stall high 3 cycles, wb_valid in cycle 4, wb_data=0xFFFFFFFFFFFFFF80, mem_addr=0x1000.
- SH addr=0x2006, wdata=0xBEEF -> mem_wstrb=0xC0, mem_wdata[63:48]=0xBEEF, mem_we=1, no wb_valid, total 3 cycles.
- LW addr=0x3002 -> err_misalign pulse in cycle 2, mem_req_valid never asserted, stall high only in cycle 1.
- LD with mem_req_ready low 5 cycles, then rsp after 3 more -> mem_addr/mem_req_valid stable throughout, wb_data=mem_rdata exactly.
- rst_n low during WAIT_RSP, then late mem_rsp_valid -> all outputs 0, no wb_valid.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready held low -> err_timeout after 4 cycles in REQ, then IDLE, stall released.
